// File: rtl/mem_initiator_if.sv
// Core-side request/response and memory-side valid/ready bundles for mem_initiator.
// Master drives the request, slave answers it.

interface mem_req_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   modport master (
      output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

interface mem_bus_if;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mem_initiator.sv
// Turns one core load/store into a single aligned word access with byte strobes,
// waits for the responder and returns lane-extracted, extended data or an error.

module mem_initiator #(
   parameter int unsigned TIMEOUT = 16,
   parameter bit          INSTR   = 1'b0
) (
   input  logic      clk,
   input  logic      rst,
   mem_req_if.slave  core,
   mem_bus_if.master mem
);

   localparam int unsigned DW    = 32;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e           state_q, state_d;
   logic             store_q, store_d;
   logic [1:0]       size_q, size_d;
   logic             uns_q, uns_d;
   logic [1:0]       off_q, off_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             mem_valid_q, mem_valid_d;
   logic [DW-1:0]    mem_addr_q, mem_addr_d;
   logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
   logic [SW-1:0]    mem_wstrb_q, mem_wstrb_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_error_q, rsp_error_d;
   logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;

   logic             misaligned_c;
   logic [SW-1:0]    wstrb_c;
   logic [DW-1:0]    wdata_c;
   logic [7:0]       lane_b_c;
   logic [15:0]      lane_h_c;
   logic [DW-1:0]    load_c;

   // Request decode from the live inputs, used only on the accept cycle
   always_comb begin
      misaligned_c = (core.req_size == 2'd3) ||
                     ((core.req_size == 2'd1) && core.req_addr[0]) ||
                     ((core.req_size == 2'd2) && (core.req_addr[1:0] != 2'b00));
      case (core.req_size)
         2'd0: begin
            wstrb_c = SW'(4'b0001 << core.req_addr[1:0]);
            wdata_c = {4{core.req_wdata[7:0]}};
         end
         2'd1: begin
            wstrb_c = core.req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{core.req_wdata[15:0]}};
         end
         default: begin
            wstrb_c = 4'b1111;
            wdata_c = core.req_wdata;
         end
      endcase
      if (!core.req_store) wstrb_c = '0;
   end

   // Lane extraction and extension of the returned word
   always_comb begin
      lane_b_c = mem.mem_rdata[{off_q, 3'b000} +: 8];
      lane_h_c = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      case (size_q)
         2'd0:    load_c = uns_q ? {24'd0, lane_b_c} : {{24{lane_b_c[7]}}, lane_b_c};
         2'd1:    load_c = uns_q ? {16'd0, lane_h_c} : {{16{lane_h_c[15]}}, lane_h_c};
         default: load_c = mem.mem_rdata;
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      store_d     = store_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      mem_valid_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = '0;

      case (state_q)
         IDLE: begin
            if (core.req_valid) begin
               store_d = core.req_store;
               size_d  = core.req_size;
               uns_d   = core.req_unsigned;
               off_d   = core.req_addr[1:0];
               if (misaligned_c) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b1;
               end else begin
                  state_d     = ISSUE;
                  mem_valid_d = 1'b1;
                  mem_addr_d  = {core.req_addr[31:2], 2'b00};
                  mem_wstrb_d = wstrb_c;
                  mem_wdata_d = wdata_c;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = '0;
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A ready in the final counted cycle still completes normally
            if (mem.mem_ready) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = store_q ? '0 : load_c;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         store_q     <= 1'b0;
         size_q      <= 2'd0;
         uns_q       <= 1'b0;
         off_q       <= 2'd0;
         cnt_q       <= '0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         store_q     <= store_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign core.req_ready = (state_q == IDLE);
   assign core.rsp_valid = rsp_valid_q;
   assign core.rsp_error = rsp_error_q;
   assign core.rsp_rdata = rsp_rdata_q;
   assign mem.mem_valid  = mem_valid_q;
   assign mem.mem_instr  = INSTR;
   assign mem.mem_addr   = mem_addr_q;
   assign mem.mem_wdata  = mem_wdata_q;
   assign mem.mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: directed cases plus random traffic against a byte-level
// memory reference and a simple latency-programmable responder.

module tb_mem_initiator;

   localparam int unsigned TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;

   mem_req_if core_if ();
   mem_bus_if mem_if ();

   mem_initiator #(.TIMEOUT(TIMEOUT), .INSTR(1'b0)) dut (
      .clk  (clk),
      .rst  (rst),
      .core (core_if),
      .mem  (mem_if)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [7:0]  ref_mem  [int unsigned];
   logic [31:0] resp_mem [int unsigned];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   function automatic int unsigned nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [7:0] ref_rd(input int unsigned a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   function automatic logic [31:0] resp_rd(input int unsigned k);
      return resp_mem.exists(k) ? resp_mem[k] : 32'h0;
   endfunction

   function automatic void preload(input logic [31:0] wa, input logic [31:0] v);
      int unsigned k;
      k = int'(wa >> 2);
      resp_mem[k] = v;
      for (int i = 0; i < 4; i++) ref_mem[int'(wa) + i] = v[8*i +: 8];
   endfunction

   // Little-endian read of n bytes, then sign or zero extension
   function automatic logic [31:0] ref_load(input logic [31:0] a, input int unsigned n, input logic un);
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < int'(n); i++) v[8*i +: 8] = ref_rd(int'(a) + i);
      if (n < 4 && !un && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   // One transaction; lat = cycles from mem_valid to mem_ready, 0 = responder silent
   task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd, input int lat,
                         output logic [31:0] got);
      int unsigned n;
      logic        mis, tmo;
      int          rsp_cyc, rdy_cyc, end_cyc;
      logic [31:0] e_rdata, e_wdata, e_addr;
      logic [3:0]  e_wstrb, cap_wstrb;
      logic [31:0] cap_wdata, cur;
      int unsigned k;

      n       = nbytes(sz);
      mis     = (sz == 2'd3) || ((a % n) != 0);
      tmo     = !mis && (lat == 0 || lat > int'(TIMEOUT));
      rsp_cyc = mis ? 1 : (tmo ? int'(TIMEOUT) + 2 : lat + 2);
      rdy_cyc = (mis || lat == 0) ? -1 : lat + 1;
      end_cyc = (rdy_cyc + 1 > rsp_cyc + 1) ? rdy_cyc + 1 : rsp_cyc + 1;
      e_addr  = a & 32'hFFFF_FFFC;
      e_wstrb = 4'b0000;
      for (int j = 0; j < 4; j++) e_wdata[8*j +: 8] = wd[8*(j % int'(n)) +: 8];
      if (st) for (int i = 0; i < int'(n); i++) e_wstrb[(int'(a[1:0]) + i) % 4] = 1'b1;
      e_rdata = (st || mis || tmo) ? 32'h0 : ref_load(a, n, un);
      if (st && !mis && !tmo)
         for (int i = 0; i < int'(n); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      k         = int'(a >> 2);
      got       = 32'h0;
      cap_wstrb = 4'b0000;
      cap_wdata = 32'h0;

      chk1("req_ready_before_accept", core_if.req_ready, 1'b1);
      core_if.req_valid    = 1'b1;
      core_if.req_store    = st;
      core_if.req_size     = sz;
      core_if.req_unsigned = un;
      core_if.req_addr     = a;
      core_if.req_wdata    = wd;

      for (int cyc = 1; cyc <= end_cyc; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            core_if.req_valid    = 1'b0;
            core_if.req_store    = 1'($urandom);
            core_if.req_size     = 2'($urandom);
            core_if.req_unsigned = 1'($urandom);
            core_if.req_addr     = $urandom;
            core_if.req_wdata    = $urandom;
         end
         chk1("mem_valid", mem_if.mem_valid, (cyc == 1) && !mis);
         chk1("mem_instr", mem_if.mem_instr, 1'b0);
         if (cyc == 1 && !mis) begin
            chk("mem_addr", mem_if.mem_addr, e_addr);
            chk("mem_wstrb", 32'(mem_if.mem_wstrb), 32'(e_wstrb));
            if (st) chk("mem_wdata", mem_if.mem_wdata, e_wdata);
            cap_wstrb = mem_if.mem_wstrb;
            cap_wdata = mem_if.mem_wdata;
         end
         chk1("rsp_valid", core_if.rsp_valid, cyc == rsp_cyc);
         if (cyc == rsp_cyc) begin
            chk1("rsp_error", core_if.rsp_error, mis || tmo);
            chk("rsp_rdata", core_if.rsp_rdata, e_rdata);
            got = core_if.rsp_rdata;
         end
         chk1("req_ready", core_if.req_ready, cyc > rsp_cyc);
         if (cyc == rdy_cyc) begin
            mem_if.mem_ready = 1'b1;
            mem_if.mem_rdata = st ? $urandom : resp_rd(k);
            if (st && !tmo) begin
               cur = resp_rd(k);
               for (int j = 0; j < 4; j++) if (cap_wstrb[j]) cur[8*j +: 8] = cap_wdata[8*j +: 8];
               resp_mem[k] = cur;
            end
         end else begin
            mem_if.mem_ready = 1'b0;
            mem_if.mem_rdata = $urandom;
         end
      end
   endtask

   initial begin
      logic [31:0] got;
      logic        st, un;
      logic [1:0]  sz;
      logic [31:0] a;
      int          lat;

      core_if.req_valid    = 1'b0;
      core_if.req_store    = 1'b0;
      core_if.req_size     = 2'd0;
      core_if.req_unsigned = 1'b0;
      core_if.req_addr     = 32'h0;
      core_if.req_wdata    = 32'h0;
      mem_if.mem_ready     = 1'b0;
      mem_if.mem_rdata     = 32'h0;

      repeat (3) @(negedge clk);
      chk1("rst_req_ready", core_if.req_ready, 1'b1);
      chk1("rst_rsp_valid", core_if.rsp_valid, 1'b0);
      chk1("rst_rsp_error", core_if.rsp_error, 1'b0);
      chk("rst_rsp_rdata", core_if.rsp_rdata, 32'h0);
      chk1("rst_mem_valid", mem_if.mem_valid, 1'b0);
      chk("rst_mem_addr", mem_if.mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_if.mem_wdata, 32'h0);
      chk("rst_mem_wstrb", 32'(mem_if.mem_wstrb), 32'h0);
      rst = 1'b1;
      @(negedge clk);

      // Word store then byte store into the same word, then word reload
      do_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1, got);
      do_req(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_00A5, 1, got);
      do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 1, got);
      chk("reload_word", got, 32'hA5AD_BEEF);

      preload(32'h0000_0010, 32'h80FF_7F01);
      do_req(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0, 1, got);
      chk("byte_load_signed", got, 32'hFFFF_FF80);
      do_req(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0, 1, got);
      chk("byte_load_unsigned", got, 32'h0000_0080);

      preload(32'h0000_0100, 32'hBEEF_1234);
      do_req(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 1, got);
      chk("half_load_unsigned", got, 32'h0000_BEEF);
      do_req(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 1, got);
      chk("half_load_signed", got, 32'hFFFF_BEEF);

      do_req(1'b0, 2'd1, 1'b0, 32'h0000_1001, 32'h0, 1, got);
      do_req(1'b1, 2'd2, 1'b0, 32'h0000_1002, 32'h1234_5678, 1, got);
      do_req(1'b0, 2'd3, 1'b0, 32'h0000_1000, 32'h0, 1, got);

      // Timeout and its edges
      do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0, got);
      do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, int'(TIMEOUT), got);
      chk("ready_at_last_wait_cycle", got, 32'h80FF_7F01);
      do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, int'(TIMEOUT) + 1, got);
      do_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h0BAD_0BAD, int'(TIMEOUT) + 2, got);
      do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 3, got);
      chk("aborted_store_not_written", got, 32'h80FF_7F01);

      // Reset while waiting for the responder
      chk1("pre_reset_ready", core_if.req_ready, 1'b1);
      core_if.req_valid = 1'b1;
      core_if.req_store = 1'b0;
      core_if.req_size  = 2'd2;
      core_if.req_addr  = 32'h0000_0040;
      @(negedge clk);
      core_if.req_valid = 1'b0;
      chk1("wait_rst_mem_valid", mem_if.mem_valid, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk1("midrst_req_ready", core_if.req_ready, 1'b1);
      chk1("midrst_mem_valid", mem_if.mem_valid, 1'b0);
      chk("midrst_mem_addr", mem_if.mem_addr, 32'h0);
      chk("midrst_mem_wstrb", 32'(mem_if.mem_wstrb), 32'h0);
      chk("midrst_mem_wdata", mem_if.mem_wdata, 32'h0);
      chk1("midrst_rsp_valid", core_if.rsp_valid, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      mem_if.mem_ready = 1'b1;
      mem_if.mem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         mem_if.mem_ready = 1'b0;
         chk1("post_rst_rsp_valid", core_if.rsp_valid, 1'b0);
         chk1("post_rst_mem_valid", mem_if.mem_valid, 1'b0);
         chk1("post_rst_req_ready", core_if.req_ready, 1'b1);
      end

      // Random traffic over a few small regions so accesses collide
      for (int t = 0; t < 150; t++) begin
         st  = 1'($urandom);
         sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         un  = 1'($urandom);
         a   = (32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 31));
         lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 2));
         do_req(st, sz, un, a, $urandom, lat, got);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
Initiator side of the single-cycle valid/ready memory port used by the testbench DRAM model.
- Accepts one load/store request at a time from the core: byte, half or word, signed or unsigned.
- Converts it into one aligned word access with byte strobes.
- Waits for the responder's ready pulse, then returns the lane-extracted, extended read data to the core.
- Detects misalignment and responder timeout, and reports both as errors.

Parameters:
TIMEOUT, 16, cycles to wait in WAIT for mem_ready before an error response (≥1)
INSTR, 0, constant value driven on mem_instr (1 = instruction fetch port)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active low
req_valid  in  1  core request strobe
req_ready  out  1  high in IDLE only; request accepted when req_valid & req_ready
req_store  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as misaligned)
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_error  out  1  qualified by rsp_valid: misaligned or timeout
mem_valid  out  1  memory request, exactly one cycle per access
mem_instr  out  1  tied to INSTR
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  32  store data replicated to all lanes
mem_wstrb  out  4  byte enables; 0000 for loads
mem_ready  in  1  responder completion, arrives ≥1 cycle after mem_valid
mem_rdata  in  32  read data, valid with mem_ready

Behaviour:
Reset (rst=0, asynchronous):
- State = IDLE; req_ready=1.
- rsp_valid, rsp_error, mem_valid, mem_wstrb, mem_addr, mem_wdata, rsp_rdata, timeout counter all 0.
- Reset mid-access abandons the access; no response is issued after release.

States: IDLE, ISSUE, WAIT, RESP. All outputs are registered except req_ready = (state==IDLE).

IDLE:
- On accept, latch store, size, unsigned, addr[1:0] and wdata.
- Misaligned (half with addr[0]=1, word with addr[1:0]≠0, size=3): go to RESP with rsp_error=1. mem_valid never asserts.
- Otherwise go to ISSUE.

ISSUE (one cycle):
- mem_valid=1; mem_addr aligned.
- Strobes from offset: byte → 1<<addr[1:0]; half → 0011 or 1100; word → 1111.
- mem_wstrb forced to 0000 for loads.
- mem_wdata: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Next state: WAIT. Counter cleared.

WAIT:
- mem_valid=0; counter increments each cycle.
- On mem_ready: extract lane mem_rdata[8*off +: 8] or [16*off[1] +: 16], extend per req_unsigned, and go to RESP with rsp_error=0.
- Word loads ignore req_unsigned. Stores return rsp_rdata=0.
- Counter == TIMEOUT-1 without mem_ready: go to RESP with rsp_error=1 and rsp_rdata=0.
- mem_ready and timeout in the same cycle: mem_ready wins.

RESP (one cycle):
- rsp_valid=1; next state IDLE.
- rsp_valid, rsp_error and rsp_rdata clear on leaving RESP.

Latency:
- Against a responder that returns ready one cycle after valid: accept at T, mem_valid at T+1, mem_ready at T+2, rsp_valid at T+3.
- Next accept no earlier than T+4.
- Misaligned request: rsp_valid at T+1.

Other rules:
- mem_ready seen in IDLE, ISSUE or RESP is ignored.
- mem_valid is never high for two consecutive cycles.
- req_* inputs are sampled only on accept; later changes have no effect.

Test Plan:
- Word store, addr 0x00000010, wdata 0xDEADBEEF → one mem_valid cycle, mem_addr 0x10, wstrb 1111, mem_wdata 0xDEADBEEF; rsp_valid 3 cycles after accept, rsp_error 0, rsp_rdata 0.
- Byte store, addr 0x13, wdata 0x000000A5 → wstrb 1000, mem_wdata 0xA5A5A5A5, mem_addr 0x10; word reload returns 0xA5ADBEEF (after the word store above).
- Byte load, signed, addr 0x13, mem_rdata 0x80FF7F01 → rsp_rdata 0xFFFFFF80. Same with req_unsigned=1 → 0x00000080.
- Half load, unsigned, addr 0x102, mem_rdata 0xBEEF1234 → wstrb 0000, rsp_rdata 0x0000BEEF. Signed → 0xFFFFBEEF.
- Misaligned half at addr 0x1001, and word at addr 0x1002 → no mem_valid; rsp_valid at T+1 with rsp_error 1.
- Responder silent, TIMEOUT=16 → rsp_valid with rsp_error 1 at T+1+16+1. Separately, rst=0 pulsed in WAIT → all outputs 0 and req_ready 1 after release; no stale rsp_valid; a late mem_ready in IDLE is ignored.
